reu_addr_counters: RTL

//  REU address/length register bank directly downstream of the DMA sequencer: holds C64 address,
//  REU address+bank and transfer length, each with an autoload shadow. Steps counters on

---
 rtl/reu_pkg.sv | 36 +++
 rtl/reu_reload_counter.sv | 62 ++++++
 rtl/reu_addr_counters.sv | 125 ++++++++++++
 3 files changed

// File: rtl/reu_pkg.sv
// Shared definitions for the REU address/length register bank: register offsets,
//   reset constants and $DF0A fix-bit positions.
// No logic of its own; no timing or flow-control behaviour.
package reu_pkg;

  // Register offsets within $DF00-$DF0F
  localparam logic [3:0] REG_CALO    = 4'h2;
  localparam logic [3:0] REG_CAHI    = 4'h3;
  localparam logic [3:0] REG_REUALO  = 4'h4;
  localparam logic [3:0] REG_REUAHI  = 4'h5;
  localparam logic [3:0] REG_BANK    = 4'h6;
  localparam logic [3:0] REG_LENLO   = 4'h7;
  localparam logic [3:0] REG_LENHI   = 4'h8;
  localparam logic [3:0] REG_ADDRCTL = 4'hA;

  // Length resets to $FFFF; a live length of $0000 means 65536 bytes
  localparam logic [15:0] LEN_RESET = 16'hFFFF;
  localparam logic [15:0] LEN_ONE   = 16'h0001;

  // Undriven / unimplemented bits read back as 1
  localparam logic [7:0] OPEN_BUS = 8'hFF;

  // Bit positions of the fix flags in $DF0A
  localparam int FIX_CA_BIT   = 7;
  localparam int FIX_REUA_BIT = 6;

  // Build the $DF0A readback byte: fix flags in place, all other bits high
  function automatic logic [7:0] ctl_readback(input logic fix_ca, input logic fix_reua);
    logic [7:0] r;
    r               = OPEN_BUS;
    r[FIX_CA_BIT]   = fix_ca;
    r[FIX_REUA_BIT] = fix_reua;
    return r;
  endfunction

endpackage

// File: rtl/reu_reload_counter.sv
// Counter with autoload shadow: byte-lane CPU load, step up/down, force-set, reload.
// Latency: one falling clock edge for every update; value is a plain register output.
// Backpressure: none; every event is accepted on the edge where it is presented.
//
// Ports:
//   clk, rst_n     falling-edge clock, async active-low reset (live and shadow -> RST)
//   wr_lane/wr_dat per-byte CPU write; loads live and shadow bits of the lane
//   step           increment (UP=1) or decrement (UP=0), wrapping at 2^W
//   set/set_val    force live value (below reload in priority)
//   reload         copy shadow into live value (highest counter priority)
//   value          live counter value
module reu_reload_counter #(
  parameter int         W   = 16,
  parameter bit         UP  = 1'b1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [(W+7)/8-1:0]     wr_lane,
  input  logic [7:0]             wr_dat,
  input  logic                   step,
  input  logic                   set,
  input  logic [W-1:0]           set_val,
  input  logic                   reload,
  output logic [W-1:0]           value
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] shadow;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] bit_wr;
  logic [W-1:0] bit_dat;

  // Spread the byte-lane strobes and write byte across the W bits
  for (genvar i = 0; i < W; i++) begin : g_lane
    assign bit_wr[i]  = wr_lane[i/8];
    assign bit_dat[i] = wr_dat[i%8];
  end

  always_comb begin
    cnt_nxt = value;
    if (reload)
      cnt_nxt = shadow;
    else if (set)
      cnt_nxt = set_val;
    else if (step)
      cnt_nxt = UP ? (value + ONE) : (value - ONE);
  end

  // A CPU write owns its byte lane; untouched lanes follow the counter result
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value  <= RST;
      shadow <= RST;
    end else begin
      value  <= (cnt_nxt & ~bit_wr) | (bit_dat & bit_wr);
      shadow <= (shadow  & ~bit_wr) | (bit_dat & bit_wr);
    end
  end

endmodule

// File: rtl/reu_addr_counters.sv
// REU address/length register bank: C64 address, REU address+bank, length, each with shadow.
// Latency: counters/registers update on falling PHI2; RegDout and Length1 are combinational.
// Backpressure: none; sequencer pulses and CPU writes are always accepted.
//
// Ports:
//   PHI2, nRESET         clock (falling-edge updates), async active-low reset
//   RegAddr/RegDin/RegWR CPU register access at $DF02-$DF0A; RegDout readback
//   Autoload             reload from shadows at XferEnd instead of finalising
//   NextCA/NextREUA      step C64 address / REU address + length
//   XferEnd              last transfer cycle
//   CA/REUA/REUBank      DMA address buses
//   FixCA/FixREUA        address hold flags from $DF0A
//   Length1              live length equals 1
module reu_addr_counters
  import reu_pkg::*;
#(
  parameter int BANK_BITS = 3
) (
  input  logic                 PHI2,
  input  logic                 nRESET,
  input  logic [3:0]           RegAddr,
  input  logic [7:0]           RegDin,
  input  logic                 RegWR,
  output logic [7:0]           RegDout,
  input  logic                 Autoload,
  input  logic                 NextCA,
  input  logic                 NextREUA,
  input  logic                 XferEnd,
  output logic [15:0]          CA,
  output logic [15:0]          REUA,
  output logic [BANK_BITS-1:0] REUBank,
  output logic                 FixCA,
  output logic                 FixREUA,
  output logic                 Length1
);

  localparam int RW = 16 + BANK_BITS;

  logic [RW-1:0] reu_full;
  logic [15:0]   len;

  logic wr_calo, wr_cahi, wr_reualo, wr_reuahi, wr_bank, wr_lenlo, wr_lenhi, wr_ctl;

  assign wr_calo   = RegWR && (RegAddr == REG_CALO);
  assign wr_cahi   = RegWR && (RegAddr == REG_CAHI);
  assign wr_reualo = RegWR && (RegAddr == REG_REUALO);
  assign wr_reuahi = RegWR && (RegAddr == REG_REUAHI);
  assign wr_bank   = RegWR && (RegAddr == REG_BANK);
  assign wr_lenlo  = RegWR && (RegAddr == REG_LENLO);
  assign wr_lenhi  = RegWR && (RegAddr == REG_LENHI);
  assign wr_ctl    = RegWR && (RegAddr == REG_ADDRCTL);

  logic reload, finalise;
  assign reload   = XferEnd && Autoload;
  // Without autoload the transfer ends with length parked at 1, not decremented
  assign finalise = XferEnd && !Autoload;

  reu_reload_counter #(.W(16), .UP(1'b1), .RST(16'h0000)) u_ca (
    .clk     (PHI2),
    .rst_n   (nRESET),
    .wr_lane ({wr_cahi, wr_calo}),
    .wr_dat  (RegDin),
    .step    (NextCA && !FixCA),
    .set     (1'b0),
    .set_val (16'h0000),
    .reload  (reload),
    .value   (CA)
  );

  // Bank sits directly above REUA so the REUA carry increments it and it wraps naturally
  reu_reload_counter #(.W(RW), .UP(1'b1), .RST('0)) u_reua (
    .clk     (PHI2),
    .rst_n   (nRESET),
    .wr_lane ({wr_bank, wr_reuahi, wr_reualo}),
    .wr_dat  (RegDin),
    .step    (NextREUA && !FixREUA),
    .set     (1'b0),
    .set_val ('0),
    .reload  (reload),
    .value   (reu_full)
  );

  // Length always steps on NextREUA, even when the REU address is held
  reu_reload_counter #(.W(16), .UP(1'b0), .RST(LEN_RESET)) u_len (
    .clk     (PHI2),
    .rst_n   (nRESET),
    .wr_lane ({wr_lenhi, wr_lenlo}),
    .wr_dat  (RegDin),
    .step    (NextREUA),
    .set     (finalise),
    .set_val (LEN_ONE),
    .reload  (reload),
    .value   (len)
  );

  assign REUA    = reu_full[15:0];
  assign REUBank = reu_full[16 +: BANK_BITS];
  assign Length1 = (len == LEN_ONE);

  always_ff @(negedge PHI2 or negedge nRESET) begin
    if (!nRESET) begin
      FixCA   <= 1'b0;
      FixREUA <= 1'b0;
    end else if (wr_ctl) begin
      FixCA   <= RegDin[FIX_CA_BIT];
      FixREUA <= RegDin[FIX_REUA_BIT];
    end
  end

  always_comb begin
    RegDout = OPEN_BUS;
    case (RegAddr)
      REG_CALO:    RegDout = CA[7:0];
      REG_CAHI:    RegDout = CA[15:8];
      REG_REUALO:  RegDout = REUA[7:0];
      REG_REUAHI:  RegDout = REUA[15:8];
      REG_BANK:    RegDout = {{(8-BANK_BITS){1'b1}}, REUBank};
      REG_LENLO:   RegDout = len[7:0];
      REG_LENHI:   RegDout = len[15:8];
      REG_ADDRCTL: RegDout = ctl_readback(FixCA, FixREUA);
      default:     RegDout = OPEN_BUS;
    endcase
  end

endmodule
